// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential divider: default operand width,
// FSM state encoding, the divide-by-zero quotient constant and a helper
// that sizes the iteration counter.
package seq_divider_32_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    // Bits needed to hold the values 0..w (iteration counter).
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle of the sequential divider.
//   start        : request a divide (sampled only in IDLE)
//   dividend     : unsigned dividend, captured with start
//   divisor      : unsigned divisor, captured with start
//   busy         : divide in progress
//   done         : one-cycle pulse when results become valid
//   quotient     : registered quotient
//   remainder    : registered remainder
//   div_by_zero  : registered divide-by-zero flag, held with results
// master drives the request, slave is the divider.
interface seq_divider_32_if
    import seq_divider_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_32_sub_cla_33.sv
// Combinational N-bit subtractor (a - b) built from 4-bit carry-lookahead
// blocks chained block to block. Computed as a + ~b + 1.
//   a, b        : operands
//   difference  : a - b modulo 2**N
//   borrow_out  : 1 when b > a
module sub_cla_33 #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] difference,
    output logic         borrow_out
);

    localparam int unsigned NB = (N + 3) / 4;
    localparam int unsigned PW = NB * 4;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] bn_ext;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   cv;
    logic [3:0]    gb;
    logic [3:0]    pb;
    logic          ci;

    always_comb begin
        a_ext          = '0;
        a_ext[N-1:0]   = a;
        bn_ext         = '0;
        bn_ext[N-1:0]  = ~b;
        g              = a_ext & bn_ext;
        p              = a_ext ^ bn_ext;
        cv             = '0;
        gb             = '0;
        pb             = '0;
        ci             = 1'b1;
        for (int unsigned k = 0; k < NB; k++) begin
            gb = g[4*k +: 4];
            pb = p[4*k +: 4];
            cv[4*k]   = ci;
            cv[4*k+1] = gb[0] | (pb[0] & ci);
            cv[4*k+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
            cv[4*k+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                      | (pb[2] & pb[1] & pb[0] & ci);
            ci        = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                      | (pb[3] & pb[2] & pb[1] & gb[0])
                      | (pb[3] & pb[2] & pb[1] & pb[0] & ci);
        end
        cv[PW] = ci;
    end

    assign difference = p[N-1:0] ^ cv[N-1:0];
    // No carry out of the top bit means the subtraction borrowed.
    assign borrow_out = ~cv[N];

    // Carries past bit N only exist because of the 4-bit padding.
    logic unused_pad_carries;
    assign unused_pad_carries = ^cv;

endmodule

// File: rtl/seq_divider_32.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : request/result bundle (slave side), see seq_divider_32_if
// A divide with nonzero divisor takes WIDTH RUN cycles and then one DONE
// cycle; a zero divisor goes straight to DONE with quotient all ones and
// remainder equal to the dividend. Results hold until the next DONE entry.
module seq_divider_32
    import seq_divider_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic                clk,
    input logic                rst,
    seq_divider_32_if.slave    bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] remo_q;
    logic             dbz_q;

    logic             load;
    logic             load_dbz;
    logic             step;
    logic             finish;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dq_next;

    // dq_q starts as the dividend and fills with quotient bits from the
    // right as dividend bits are shifted out into the partial remainder.
    assign shifted = {rem_q, dq_q[WIDTH-1]};

    sub_cla_33 #(
        .N (WIDTH + 1)
    ) u_sub (
        .a          (shifted),
        .b          ({1'b0, dvs_q}),
        .difference (trial_diff),
        .borrow_out (trial_borrow)
    );

    assign rem_next = trial_borrow ? shifted : trial_diff;
    assign dq_next  = {dq_q[WIDTH-2:0], ~trial_borrow};

    // After keep/restore the partial remainder is below the divisor, so
    // its top bit is always zero; only the trial operand needs it.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_next[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_dbz = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        load_dbz = 1'b1;
                        state_d  = DONE;
                    end else begin
                        load     = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            if (load) begin
                rem_q <= '0;
                dq_q  <= bus.dividend;
                dvs_q <= bus.divisor;
                cnt_q <= CW'(WIDTH);
            end
            if (step) begin
                rem_q <= rem_next[WIDTH-1:0];
                dq_q  <= dq_next;
                cnt_q <= cnt_q - CW'(1);
            end
            // The final iteration's results go straight to the output
            // registers on the same edge that enters DONE.
            if (finish) begin
                quo_q  <= dq_next;
                remo_q <= rem_next[WIDTH-1:0];
                dbz_q  <= 1'b0;
            end
            if (load_dbz) begin
                quo_q  <= WIDTH'(DBZ_QUOTIENT);
                remo_q <= bus.dividend;
                dbz_q  <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: directed cases followed by
// randomized back-to-back divides compared with plain / and % arithmetic.
module tb_seq_divider_32;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_32_if #(.WIDTH(W)) bus ();

    seq_divider_32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide and watches it to completion. lat counts clock edges
    // from the accepting edge (inclusive) to the sample where done is high.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                           output int lat, output int ndone, output logic busy_bad,
                           output logic hold_bad);
        q = '0; r = '0; dz = 1'b0;
        lat = -1; ndone = 0; busy_bad = 1'b0; hold_bad = 1'b0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        for (int i = 1; i <= int'(W) + 8; i++) begin
            if (i == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd9;
                bus.divisor  = 32'd3;
            end else begin
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            if (bus.busy !== ((b != 0) && !bus.done)) busy_bad = 1'b1;
            if (bus.done === 1'b1) begin
                ndone++;
                lat = i;
                q   = bus.quotient;
                r   = bus.remainder;
                dz  = bus.div_by_zero;
                break;
            end
            tick();
        end
        bus.start = 1'b0;
        tick();
        if (bus.done !== 1'b0) ndone++;
        if (bus.busy !== 1'b0) busy_bad = 1'b1;
        if (bus.quotient !== q || bus.remainder !== r || bus.div_by_zero !== dz) hold_bad = 1'b1;
    endtask

    task automatic div_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int inject_at);
        logic [W-1:0] q, r, eq, er;
        logic         dz, busy_bad, hold_bad;
        int           lat, ndone, elat;
        if (b == 0) begin
            eq = '1; er = a; elat = 1;
        end else begin
            eq = a / b; er = a % b; elat = int'(W) + 1;
        end
        run_div(a, b, inject_at, q, r, dz, lat, ndone, busy_bad, hold_bad);
        check({tag, ".quotient"}, q, eq);
        check({tag, ".remainder"}, r, er);
        check({tag, ".div_by_zero"}, dz, (b == 0));
        check({tag, ".latency"}, lat, elat);
        check({tag, ".done_pulses"}, ndone, 1);
        check({tag, ".busy_bad"}, busy_bad, 0);
        check({tag, ".hold_bad"}, hold_bad, 0);
    endtask

    initial begin
        int stray;
        logic [W-1:0] a, b;
        int unsigned mode;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        #12;
        check("reset.quotient", bus.quotient, 0);
        check("reset.remainder", bus.remainder, 0);
        check("reset.div_by_zero", bus.div_by_zero, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        tick();
        rst = 1'b0;
        tick();

        div_and_check("d100_7", 32'd100, 32'd7, 0);
        div_and_check("dmax_1", 32'hFFFFFFFF, 32'd1, 0);
        div_and_check("dfe_ff", 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        // Second start mid-run must be ignored and not queued.
        div_and_check("d100_7_inject", 32'd100, 32'd7, 10);
        div_and_check("d9_3", 32'd9, 32'd3, 0);
        div_and_check("d5_0", 32'd5, 32'd0, 0);

        // Asynchronous reset in the middle of a divide.
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst.quotient", bus.quotient, 0);
        check("midrst.remainder", bus.remainder, 0);
        check("midrst.div_by_zero", bus.div_by_zero, 0);
        check("midrst.busy", bus.busy, 0);
        check("midrst.done", bus.done, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        stray = 0;
        repeat (40) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        check("midrst.stray_activity", stray, 0);
        div_and_check("d50_8", 32'd50, 32'd8, 0);

        for (int n = 0; n < 1000; n++) begin
            mode = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = 32'd1;
                1: begin
                    a = 32'($urandom_range(0, 1000));
                    b = a + 32'd1 + 32'($urandom_range(0, 100000));
                end
                2: b = '0;
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            div_and_check("rnd", a, b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, captured with start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, captured with start.
REQ-007 SHALL have port busy  output  1  high while a divide is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag, valid with done, held with results.

Function
REQ-012 SHALL implement an unsigned restoring divider, one quotient bit per clock, MSB first.
REQ-013 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start with divisor!=0; IDLE->DONE on start with divisor==0; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 SHALL capture dividend and divisor on the start edge; later input changes SHALL NOT affect the operation.
REQ-015 Each RUN cycle SHALL shift {partial_rem, dividend_shift} left by 1, trial-subtract divisor from the WIDTH+1-bit partial remainder, keep the difference and set quotient bit 1 when no borrow, else restore and set bit 0.
REQ-016 Iteration counter SHALL count WIDTH down to 1 (width ceil(log2(WIDTH+1))); RUN exits on the edge where the counter equals 1.
REQ-017 Latency: start accepted on edge t0 -> busy high from t0 through t0+WIDTH; done high in the cycle after edge t0+WIDTH (DONE state), exactly one cycle.
REQ-018 Divide-by-zero latency: done high in the cycle after t0; quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-019 quotient, remainder, div_by_zero SHALL update only when entering DONE and SHALL hold until the next DONE entry.
REQ-020 start while busy or in DONE SHALL be ignored (no queuing); start in IDLE the cycle after DONE SHALL be accepted.
REQ-021 div_by_zero SHALL be 0 for every divide with nonzero divisor.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 rst high SHALL asynchronously force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, working registers=0.
REQ-024 rst mid-RUN SHALL abort the divide with no done pulse; first start after rst release SHALL be accepted normally.

Structure
REQ-025 WIDTH default, FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the all-ones div-by-zero quotient constant SHALL reside in the shared ALU package/header.
REQ-026 Trial subtraction SHALL be a separate combinational sub-module sub_cla_33 (WIDTH+1-bit borrow-lookahead subtractor built from 4-bit lookahead blocks, outputs difference and borrow_out).
REQ-027 The divider SHALL contain no combinational path from start/dividend/divisor to any output.

Verification
REQ-028 dividend=100, divisor=7, start one cycle -> done exactly 33 cycles after start edge, quotient=14, remainder=2, div_by_zero=0.
REQ-029 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0; divisor=32'hFFFFFFFF, dividend=32'hFFFFFFFE -> quotient=0, remainder=32'hFFFFFFFE.
REQ-030 dividend=5, divisor=0 -> done 1 cycle after start edge, quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1, busy never high.
REQ-031 100/7 started, start pulsed again with 9/3 at cycle 10 -> result still 14 r 2, no second done; 9/3 started right after done -> quotient=3, remainder=0.
REQ-032 rst asserted asynchronously at cycle 15 of 100/7 -> all outputs 0 immediately, no done; then 50/8 -> quotient=6, remainder=2.
REQ-033 Randomized back-to-back divides (1000 pairs incl. divisor=1, divisor>dividend) checked against a reference model for quotient, remainder, latency, single-cycle done.
